i2c_req_arbiter: RTL



---
 rtl/i2c_req_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Two-port round-robin arbiter for the MT9V034 SCCB/I2C write master.
// Ports: req0/1+addr/wdata in, ack/err pulses out, i2c_exec/addr/wr_data/done to master, busy.
module i2c_req_arbiter #(
  parameter logic [15:0] TIMEOUT_MAX = 16'd50000,
  parameter logic [7:0]  GAP_CYC     = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic [7:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic        i2c_exec,
  output logic [7:0]  i2c_addr,
  output logic [15:0] i2c_wr_data,
  input  logic        i2c_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
  } state_t;

  localparam logic [15:0] TO_LAST  = TIMEOUT_MAX - 16'd1;
  localparam logic [7:0]  GAP_LAST = GAP_CYC - 8'd1;

  state_t      r_state;
  logic [15:0] r_tcnt;
  logic [7:0]  r_gcnt;
  logic        r_ptr;
  logic        r_gnt;

  logic w_any;
  logic w_sel1;
  logic w_end;

  assign w_any  = req0 | req1;
  // r_ptr=1 favours requester 1 when both are asking
  assign w_sel1 = req1 & (~req0 | r_ptr);
  assign w_end  = i2c_done | (r_tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tcnt      <= 16'd0;
      r_gcnt      <= 8'd0;
      r_ptr       <= 1'b0;
      r_gnt       <= 1'b0;
      i2c_exec    <= 1'b0;
      i2c_addr    <= 8'd0;
      i2c_wr_data <= 16'd0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      i2c_exec <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt       <= w_sel1;
            r_ptr       <= ~w_sel1;
            i2c_addr    <= w_sel1 ? addr1 : addr0;
            i2c_wr_data <= w_sel1 ? wdata1 : wdata0;
            i2c_exec    <= 1'b1;
            r_tcnt      <= 16'd0;
            busy        <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_end) begin
            // done on the threshold cycle wins over the timeout
            ack0    <= ~r_gnt;
            ack1    <= r_gnt;
            err0    <= ~i2c_done & ~r_gnt;
            err1    <= ~i2c_done & r_gnt;
            r_gcnt  <= 8'd0;
            r_state <= S_GAP;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_gcnt == GAP_LAST) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 8'd1;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
